sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//  Parametrised successor to the single-digit hex decoder path. Captures an unsigned binary value,
//  converts it serially to BCD (double-dabble), then time-multiplexes DIGITS seven-segment digits.
//  Adds leading-zero blanking, overflow indication and output polarity selection.
//  Sits between the game logic (ui_in / score) and the uo_out/uio_out segment/digit-enable pins.
// PARAMETERS
//  VALUE_W       8     width of binary input value
//  DIGITS        3     number of decimal digits driven (>=1)
//  REFRESH_DIV   1024  clk cycles each digit stays enabled (>=2)
//  BLANK_LEADING 1     1: blank leading zero digits (digit 0 always lit)
//  COMMON_ANODE  0     1: seg and dig_en are active-low; 0: active-high
// PORTS
//  clk     in   1        system clock, rising edge
//  rst     in   1        asynchronous reset, active-high
//  value   in   VALUE_W  binary value, sampled only on accepted load
//  load    in   1        request capture+conversion of value
//  busy    out  1        conversion in progress; load ignored while high
//  seg     out  7        segments, seg[0]=a .. seg[6]=g (polarity per COMMON_ANODE)
//  dig_en  out  DIGITS   one-hot digit enable, bit 0 = least significant digit
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-high (rst). All flops clear immediately on rst.
//  - Reset values: busy=0, seg=all off, dig_en=all inactive, display BCD regs=0, scan idx=0, div cnt=0.
//    After release, first output cycle shows "0" on digit 0 (others blanked if BLANK_LEADING).
//  - Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//    IDLE: load=1 at edge t latches value, clears scratch BCD, shift cnt=0; busy=1 from t+1.
//    SHIFT: VALUE_W cycles; each cycle add 3 to every scratch nibble >=5, then shift left 1 bit
//      pulling value MSB in. Any 1 shifted out of top nibble sets ovf flag.
//    COMMIT: one cycle; copies scratch BCD + ovf into display regs atomically; busy drops next edge.
//    busy high exactly VALUE_W+1 cycles; new digits visible on seg from the cycle after COMMIT.
//  - load while busy: ignored, no queueing. load held high in IDLE restarts on each IDLE entry.
//  - Scan: divider counts 0..REFRESH_DIV-1; on wrap, idx advances 0..DIGITS-1 then wraps to 0.
//    Scan runs continuously, independent of conversion; COMMIT does not reset idx/divider.
//  - Glyphs: BCD 0-9 standard patterns (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F, active-high).
//    Blank digit -> 00. Overflow (ovf=1) -> every digit shows dash 40, blanking overridden.
//  - Blanking: digit k>0 blanked iff BLANK_LEADING and all display nibbles >=k are zero.
//  - seg and dig_en are registered (1-cycle latency from idx/display regs); never two dig_en active.
//  - COMMON_ANODE=1 inverts seg and dig_en at output flop input (reset value = all ones then).
// STRUCTURE
//  - Shared package sevenseg_pkg: SEG_BLANK, SEG_DASH, glyph table/function digit->7-bit pattern,
//    FSM state enum (ST_IDLE, ST_SHIFT, ST_COMMIT).
//  - Sub-module bin2bcd_serial (VALUE_W, DIGITS): start/busy/done, bcd out, ovf out; contains FSM.
//  - Top holds divider, scan index, blanking mux, glyph lookup, polarity and output registers.
// TESTING (bench: VALUE_W=8, DIGITS=3, REFRESH_DIV=4, BLANK_LEADING=1, COMMON_ANODE=0 unless noted)
//  1 rst asserted mid-SHIFT -> same cycle busy=0, dig_en=000, seg=00; after release digit0 seg=3F.
//  2 load value=173 -> busy high 9 cycles; scan shows dig_en 001:4F, 010:07, 100:06, 4 cycles each, repeating.
//  3 load value=5 -> dig_en 001 seg=6D; dig_en 010 and 100 seg=00 (blanked).
//  4 load 173 then load 42 on 3rd busy cycle -> 42 ignored, display 173; load 42 after busy=0 -> shows 42.
//  5 DIGITS=2, load 200 -> ovf; both digits seg=40; then load 99 -> 6F,6F.
//  6 COMMON_ANODE=1, value=0 -> reset seg=7F dig_en=111; digit0 active: dig_en=110 seg=40 (~3F).

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants, conversion FSM states and the BCD-to-segment glyph table
// for the scanned seven-segment display path.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    // Active-high patterns, bit 0 = segment a .. bit 6 = segment g.
    function automatic logic [6:0] glyph(input logic [3:0] digit);
        logic [6:0] g;
        case (digit)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Load/busy handshake plus segment and digit-enable pins of the display driver.
interface sevenseg_scan_driver_if #(
    parameter int VALUE_W = 8,
    parameter int DIGITS  = 3
);
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               busy;
    logic [6:0]         seg;
    logic [DIGITS-1:0]  dig_en;

    modport master (output value, load, input busy, seg, dig_en);
    modport slave  (input value, load, output busy, seg, dig_en);
endinterface

// File: rtl/sevenseg_scan_driver_bin2bcd_serial.sv
// Serial double-dabble converter: VALUE_W shift cycles plus one commit cycle.
// done pulses during the commit cycle while bcd/ovf hold the finished result.
module bin2bcd_serial
    import sevenseg_pkg::*;
#(
    parameter int VALUE_W = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_W - 1);

    conv_state_t        state;
    logic [VALUE_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   adj;

    // NOTE: adj gets its full default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: state is written with <= only, so every flop sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= value;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A carry out of the top nibble means the value needs more digits.
                    bcd   <= {adj[BCD_W-2:0], shreg[VALUE_W-1]};
                    ovf   <= ovf | adj[BCD_W-1];
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= ST_COMMIT;
                        done  <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Captures a binary value, converts it to BCD and time-multiplexes DIGITS
// seven-segment digits with leading-zero blanking, overflow dash and polarity.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int VALUE_W       = 8,
    parameter int DIGITS        = 3,
    parameter int REFRESH_DIV   = 1024,
    parameter int BLANK_LEADING = 1,
    parameter int COMMON_ANODE  = 0
) (
    input logic                   clk,
    input logic                   rst,
    sevenseg_scan_driver_if.slave bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = (COMMON_ANODE != 0) ? '1 : '0;

    logic [4*DIGITS-1:0] conv_bcd;
    logic                conv_ovf;
    logic                conv_busy;
    logic                conv_done;

    logic [4*DIGITS-1:0] disp_bcd;
    logic                disp_ovf;
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   dig_q;

    logic [DIGITS-1:0]   blank_vec;
    logic                any_hi;
    logic [3:0]          nibble;
    logic [6:0]          glyph_d;
    logic [DIGITS-1:0]   onehot_d;

    bin2bcd_serial #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (bus.load),
        .value (bus.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign bus.busy   = conv_busy;
    assign bus.seg    = seg_q;
    assign bus.dig_en = dig_q;

    // Digit k is blank when it and every more significant nibble are zero.
    always_comb begin
        any_hi    = 1'b0;
        blank_vec = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            any_hi       = any_hi | (disp_bcd[4*k +: 4] != 4'd0);
            blank_vec[k] = (BLANK_LEADING != 0) && (k != 0) && !any_hi;
        end
    end

    always_comb begin
        nibble   = disp_bcd[4*idx +: 4];
        onehot_d = DIGITS'(1) << idx;
        if (disp_ovf)
            glyph_d = SEG_DASH;
        else if (blank_vec[idx])
            glyph_d = SEG_BLANK;
        else
            glyph_d = glyph(nibble);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
        end else begin
            if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // Result and overflow flag land together so the display never mixes old and new.
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                disp_ovf <= conv_ovf;
            end

            seg_q <= (COMMON_ANODE != 0) ? ~glyph_d  : glyph_d;
            dig_q <= (COMMON_ANODE != 0) ? ~onehot_d : onehot_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Drives three driver variants (3-digit, 2-digit, common-anode) with shared stimulus
// and compares every cycle against an arithmetic model of the displayed number.
module tb_sevenseg_scan_driver;

    localparam int V  = 8;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] value = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    // Model state: accepted-load edge, pending value, value currently on the segments.
    int  t_acc;
    int  pend;
    int  disp_val;
    logic exp_busy;

    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    sevenseg_scan_driver_if #(.VALUE_W(8), .DIGITS(3)) bus_a ();
    sevenseg_scan_driver_if #(.VALUE_W(8), .DIGITS(2)) bus_b ();
    sevenseg_scan_driver_if #(.VALUE_W(8), .DIGITS(3)) bus_c ();

    assign bus_a.value = value;
    assign bus_a.load  = load;
    assign bus_b.value = value;
    assign bus_b.load  = load;
    assign bus_c.value = value;
    assign bus_c.load  = load;

    sevenseg_scan_driver #(.VALUE_W(8), .DIGITS(3), .REFRESH_DIV(RD),
                           .BLANK_LEADING(1), .COMMON_ANODE(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sevenseg_scan_driver #(.VALUE_W(8), .DIGITS(2), .REFRESH_DIV(RD),
                           .BLANK_LEADING(1), .COMMON_ANODE(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    sevenseg_scan_driver #(.VALUE_W(8), .DIGITS(3), .REFRESH_DIV(RD),
                           .BLANK_LEADING(1), .COMMON_ANODE(1))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int nd, input bit ca, input int k);
        logic [6:0] g;
        if (val >= pow10(nd))            g = 7'h40;
        else if (k > 0 && val < pow10(k)) g = 7'h00;
        else                              g = GLYPH[(val / pow10(k)) % 10];
        return ca ? ~g : g;
    endfunction

    function automatic logic [31:0] exp_dig(input int nd, input bit ca, input int k);
        logic [31:0] m = (32'd1 << nd) - 32'd1;
        logic [31:0] oh = 32'd1 << k;
        return ca ? (~oh & m) : oh;
    endfunction

    task automatic model_update();
        int e = cyc;
        if (t_acc >= 0 && e == t_acc + V + 2) disp_val = pend;
        if (load && (t_acc < 0 || e >= t_acc + V + 2)) begin
            t_acc = e;
            pend  = int'(value);
        end
        exp_busy = (t_acc >= 0 && e >= t_acc && e <= t_acc + V);
    endtask

    task automatic check_all();
        int k3 = ((cyc - 1) / RD) % 3;
        int k2 = ((cyc - 1) / RD) % 2;
        check("busy_a", 32'(bus_a.busy), 32'(exp_busy));
        check("busy_b", 32'(bus_b.busy), 32'(exp_busy));
        check("seg_a",  32'(bus_a.seg),    32'(exp_seg(disp_val, 3, 1'b0, k3)));
        check("dig_a",  32'(bus_a.dig_en), exp_dig(3, 1'b0, k3));
        check("seg_b",  32'(bus_b.seg),    32'(exp_seg(disp_val, 2, 1'b0, k2)));
        check("dig_b",  32'(bus_b.dig_en), exp_dig(2, 1'b0, k2));
        check("seg_c",  32'(bus_c.seg),    32'(exp_seg(disp_val, 3, 1'b1, k3)));
        check("dig_c",  32'(bus_c.dig_en), exp_dig(3, 1'b1, k3));
    endtask

    task automatic step(input logic ld, input int v);
        @(negedge clk);
        model_update();
        check_all();
        load  = ld;
        value = 8'(v);
    endtask

    // Asserts rst between edges and checks that outputs clear without waiting for a clock.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy_a", 32'(bus_a.busy),   32'd0);
        check("rst_seg_a",  32'(bus_a.seg),    32'h00);
        check("rst_dig_a",  32'(bus_a.dig_en), 32'h0);
        check("rst_seg_c",  32'(bus_c.seg),    32'h7F);
        check("rst_dig_c",  32'(bus_c.dig_en), 32'h7);
        load  = 1'b0;
        value = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        t_acc    = -1;
        pend     = 0;
        disp_val = 0;
        exp_busy = 1'b0;
    endtask

    task automatic load_and_hold(input int v, input int cycles);
        step(1'b1, v);
        repeat (cycles) step(1'b0, 0);
    endtask

    initial begin
        t_acc    = -1;
        pend     = 0;
        disp_val = 0;
        exp_busy = 1'b0;

        apply_reset();
        repeat (14) step(1'b0, 0);

        // Reset landing mid-conversion, then the display restarts from "0".
        step(1'b1, 173);
        repeat (4) step(1'b0, 0);
        apply_reset();
        repeat (6) step(1'b0, 0);

        load_and_hold(173, 36);
        load_and_hold(5, 30);

        // Second load arrives on the third busy cycle and must be dropped.
        step(1'b1, 173);
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 42);
        repeat (30) step(1'b0, 0);
        load_and_hold(42, 30);

        load_and_hold(200, 30);
        load_and_hold(99, 30);
        load_and_hold(0, 30);
        load_and_hold(255, 30);
        load_and_hold(100, 30);

        // Load held high restarts a conversion on every return to idle.
        repeat (30) step(1'b1, 7);
        repeat (30) step(1'b1, 63);
        step(1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            int v;
            case ($urandom_range(0, 4))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(90, 110);
                default: v = $urandom_range(0, 255);
            endcase
            step(($urandom_range(0, 7) == 0), v);
        end
        repeat (30) step(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
